// File: rtl/fp_pkg.sv
// Shared constants and types for the FP add/sub normalization path.
package fp_pkg;

  localparam int MW   = 28;
  localparam int EW   = 8;
  localparam int EMAX = 255;
  localparam int BIAS = 127;

  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int G      = 2;
  localparam int R      = 1;
  localparam int S      = 0;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RU  = 2'b10,
    RM_RD  = 2'b11
  } rmode_e;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic          eff_sub;
    logic [1:0]    mode;
    logic [4:0]    lz;
  } s1_word_t;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic [1:0]    mode;
    logic          ovf;
    logic          is_zero;
  } s2_word_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the 27 bits below the carry; all-zero input yields 27.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [HIDDEN:0] din,
  output logic [4:0]      lz
);

  // Ascending scan: the highest set bit is the last one to write lz.
  always_comb begin
    lz = 5'd27;
    for (int i = 0; i <= HIDDEN; i++) begin
      if (din[i]) lz = 5'(HIDDEN - i);
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Two-stage normalization of the raw adder result into the rounding-stage format.
module fp_normalize
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] mant_sum,
  input  logic [EW-1:0] exp_in,
  input  logic          sign_in,
  input  logic          eff_sub,
  input  logic [1:0]    mode_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] mantisa_norm,
  output logic [EW-1:0] exp_norm,
  output logic          sign_norm,
  output logic [1:0]    mode_out,
  output logic          ovf,
  output logic          is_zero
);

  logic [4:0]     lz;
  s1_word_t       s1_q, s1_d;
  s2_word_t       s2_q, s2_d, res;
  logic           s1_valid_q, s1_valid_d;
  logic           s2_valid_q, s2_valid_d;
  logic           in_fire, s2_advance;
  logic [EW:0]    exp9, exp_inc, smax, lz9;
  logic [4:0]     sh;
  logic [HIDDEN:0] body;

  fp_lzc u_lzc (
    .din (mant_sum[HIDDEN:0]),
    .lz  (lz)
  );

  assign s2_advance = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s2_advance;
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d = '{mant: mant_sum, exp: exp_in, sign: sign_in,
               eff_sub: eff_sub, mode: mode_in, lz: lz};
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Exponent math is kept in 9 bits so exp+1 and exp-1 never wrap.
  always_comb begin
    res      = '0;
    res.sign = s1_q.sign;
    res.mode = s1_q.mode;
    exp9     = {1'b0, s1_q.exp};
    exp_inc  = exp9 + (EW+1)'(1);
    smax     = (exp9 == '0) ? '0 : exp9 - (EW+1)'(1);
    lz9      = {4'b0, s1_q.lz};
    sh       = '0;
    body     = '0;
    if (s1_q.mant == '0) begin
      res.is_zero = 1'b1;
      res.sign    = s1_q.eff_sub ? (s1_q.mode == RM_RD) : s1_q.sign;
    end else if (s1_q.mant[CARRY]) begin
      if (exp_inc >= (EW+1)'(EMAX)) begin
        res.ovf = 1'b1;
        res.exp = '1;
      end else begin
        res.exp  = exp_inc[EW-1:0];
        res.mant = {1'b0, s1_q.mant[CARRY:G], |s1_q.mant[R:S]};
      end
    end else begin
      if (lz9 <= smax) begin
        sh      = s1_q.lz;
        res.exp = s1_q.exp - EW'(s1_q.lz);
      end else begin
        // Exponent floor reached: stop shifting and emit a denormal.
        sh = smax[4:0];
      end
      body     = s1_q.mant[HIDDEN:0] << sh;
      res.mant = {1'b0, body};
    end
  end

  always_comb begin
    s2_d       = s2_advance ? res : s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_advance) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign mantisa_norm = s2_q.mant;
  assign exp_norm     = s2_q.exp;
  assign sign_norm    = s2_q.sign;
  assign mode_out     = s2_q.mode;
  assign ovf          = s2_q.ovf;
  assign is_zero      = s2_q.is_zero;

endmodule

// File: doc/fp_normalize.md
Name: fp_normalize

Overview:
- Normalization stage of the FP add/sub datapath, directly upstream of the rounding stage.
- Takes the raw 28-bit aligned sum/difference and exponent from the adder, and corrects a carry-out by shifting right 1.
- Otherwise removes leading zeros by shifting left (limited by the exponent, producing denormals), and detects zero and overflow.
- Emits mantisa_norm/exp_norm/sign_norm in exactly the format rounding consumes: bit27 = 0 headroom, bit26 = hidden one, [25:3] fraction, [2:0] = G,R,S.
- 2-stage valid/ready pipeline; mode is carried alongside the data.

Parameters:
- MW, 28, mantissa datapath width including headroom and G/R/S.
- EW, 8, biased exponent width.
- EMAX, 255, all-ones exponent (inf/NaN encoding).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  stage can accept input
- mant_sum  in  28  raw adder result; bit27 = carry-out, bit26 = hidden position, [2:0] = G,R,S
- exp_in  in  8  biased exponent of the aligned operands; the aligner presents denormal operands with exp_in = 1
- sign_in  in  1  result sign from the adder
- eff_sub  in  1  operation was an effective subtraction
- mode_in  in  2  rounding mode (00 RNE, 01 RZ, 10 RU, 11 RD)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- mantisa_norm  out  28  normalized mantissa
- exp_norm  out  8  adjusted exponent
- sign_norm  out  1  result sign
- mode_out  out  2  mode_in delayed with the data
- ovf  out  1  exponent overflow; result forced to inf
- is_zero  out  1  exact zero result

Behaviour:
- Reset (async, any time, including mid-transfer): both stage valid bits cleared; all outputs 0 (out_valid=0, mantisa_norm=0, exp_norm=0, sign_norm=0, mode_out=0, ovf=0, is_zero=0); in-flight words are discarded.
- Pipeline: S1 registers the inputs plus lz = leading-zero count of mant_sum[26:0] (0..27) from the fp_lzc sub-module. S2 registers the shifted and adjusted result.
- Latency: 2 cycles with no back-pressure.
- Handshake:
  - A transfer occurs when valid && ready on a clock edge.
  - Each stage advances when its successor is empty or is being drained that cycle.
  - in_ready = !s1_valid || s1_advance.
  - Bubbles collapse.
  - Outputs hold stable while out_valid && !out_ready.
  - Full throughput: 1 word/cycle when out_ready = 1.
- S2 rules, in priority order:
  1. mant_sum = 0:
     - mantisa_norm = 0, exp_norm = 0, is_zero = 1.
     - sign_norm = (mode==11) if eff_sub, else sign_in.
  2. mant_sum[27] = 1 (carry):
     - mantisa_norm = {0, mant_sum[27:2], mant_sum[1] | mant_sum[0]} (sticky preserved).
     - exp = exp_in + 1.
     - If exp_in + 1 >= EMAX: ovf = 1, exp_norm = 255, mantisa_norm = 0.
  3. Otherwise, let smax = exp_in - 1:
     - lz <= smax: shift left by lz, exp_norm = exp_in - lz.
     - lz > smax: shift left by smax, exp_norm = 0 (denormal; bit26 of the result = 0).
     - Zeros enter at the LSB.
- Width: the exponent arithmetic is done in 9 bits; no wrap-around is permitted.
- sign_norm = sign_in except in rule 1. mode_out always = mode_in of the same word.

Decomposition:
- Shared package fp_pkg holds:
  - EW, MW, EMAX, BIAS=127
  - mode encodings RM_RNE=00, RM_RZ=01, RM_RU=10, RM_RD=11
  - mantissa bit positions HIDDEN=26, CARRY=27, G=2, R=1, S=0
- One sub-module, fp_lzc: combinational 27-bit leading-zero counter, 5-bit output, returns 27 for all-zero input. It is reusable by the multiplier path.

Test Plan:
- Carry: mant_sum=0x8000005, exp_in=0x80 → 2 cycles later mantisa_norm=0x4000003, exp_norm=0x81, ovf=0.
- Cancellation: mant_sum=0x0000100 (lz=18), exp_in=0x90 → mantisa_norm=0x4000000, exp_norm=0x7E.
- Denormal clamp: mant_sum=0x0000100, exp_in=0x05 → shift 4, mantisa_norm=0x0001000, exp_norm=0.
- Zero and overflow:
  - mant_sum=0, eff_sub=1, mode=11 → is_zero=1, sign_norm=1.
  - Same with mode=00 → sign_norm=0.
  - mant_sum=0x8000000, exp_in=0xFE → ovf=1, exp_norm=0xFF, mantisa_norm=0.
- Back-pressure: stream 5 words with out_ready low for cycles 3–6 → no loss or duplication; in_ready falls once both stages are full; outputs stay stable while stalled; order preserved.
- Reset mid-stream: assert rst with 2 words in flight → out_valid=0 and outputs 0 immediately; the first post-reset word appears 2 cycles after acceptance.
